// File: rtl/scan_ctrl_l9.sv
// scan_ctrl_l9: layer-9 output-feature-map scan controller.
// Walks x/y addresses row by row and issues a one-cycle x_zero strobe at each row end.
// It then stalls until the temp sequencer reports temp_done, and then starts the next row.
// Optional checker: define SCAN_CTRL_L9_CHK_EN to add the err_sticky_o handshake-error flag.
module scan_ctrl_l9 #(
  parameter int unsigned COLS = 14,
  parameter int unsigned ROWS = 14,
  parameter int unsigned XW   = 4,
  parameter int unsigned YW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          temp_busy_i,
  input  logic          temp_done_i,
  output logic          x_zero_o,
  output logic [XW-1:0] x_addr_o,
  output logic [YW-1:0] y_addr_o,
  output logic          valid_o,
  output logic          row_done_o,
  output logic          frame_done_o,
`ifdef SCAN_CTRL_L9_CHK_EN
  output logic          err_sticky_o,
`endif
  output logic          busy_o
);

  localparam logic [XW-1:0] XLast = XW'(COLS - 1);
  localparam logic [YW-1:0] YLast = YW'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_zero_q, x_zero_d;
  logic          valid_q, valid_d;
  logic          row_done_q, row_done_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  // Next-state and registered-output decode; every output is computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    x_zero_d     = 1'b0;
    valid_d      = 1'b0;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = 1'b1;
    unique case (state_q)
      StIdle: begin
        // temp_done/temp_busy ignored: the sequencer's post-reset pulse must not advance us.
        busy_d = 1'b0;
        if (start_i) begin
          state_d = StScan;
          x_d     = '0;
          y_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StScan: begin
        if (x_q == XLast) begin
          state_d  = StWait;
          x_d      = '0;
          x_zero_d = 1'b1;
        end else begin
          x_d     = x_q + XW'(1);
          valid_d = 1'b1;
        end
      end
      StWait: begin
        // temp_done is accepted even in the x_zero cycle (zero-latency sequencer).
        if (temp_done_i) begin
          row_done_d = 1'b1;
          if (y_q == YLast) begin
            state_d      = StDone;
            frame_done_d = 1'b1;
          end else begin
            state_d = StScan;
            y_d     = y_q + YW'(1);
            valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        y_d     = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        x_d     = '0;
        y_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      x_zero_q     <= 1'b0;
      valid_q      <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      x_zero_q     <= x_zero_d;
      valid_q      <= valid_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign x_zero_o     = x_zero_q;
  assign x_addr_o     = x_q;
  assign y_addr_o     = y_q;
  assign valid_o      = valid_q;
  assign row_done_o   = row_done_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;

`ifdef SCAN_CTRL_L9_CHK_EN
  logic err_q;
  logic err_set;

  // Flag an x_zero issued to a busy sequencer, or a completion arriving mid-scan.
  always_comb begin
    err_set = 1'b0;
    if (state_q == StScan) begin
      err_set = temp_done_i | ((x_q == XLast) & temp_busy_i);
    end
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  assign err_sticky_o = err_q;
`else
  logic unused_temp_busy;
  assign unused_temp_busy = temp_busy_i;
`endif

endmodule

// File: doc/scan_ctrl_l9.md
Name: scan_ctrl_l9

Overview:
- Layer-9 output-feature-map scan controller: the producing end of the x_zero / temp handshake.
- Walks column (x) and row (y) addresses and issues a one-cycle x_zero strobe at each row end.
- Stalls until the downstream temp sequencer reports completion (temp_done), then starts the next row.
- Sits between the layer-9 start/control logic and the temp counter / accumulator datapath.

Parameters:
- COLS, 14, columns per row (≥2)
- ROWS, 14, rows per frame (≥1)
- XW, 4, x_addr width; must satisfy 2^XW ≥ COLS
- YW, 4, y_addr width; must satisfy 2^YW ≥ ROWS

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame start request; sampled only in IDLE
- temp_busy  in  1  temp sequencer running (its temp_counter output)
- temp_done  in  1  temp sequencer end-of-cycle pulse (its temp==10 pulse)
- x_zero  out  1  row-end strobe to the temp sequencer
- x_addr  out  XW  current column
- y_addr  out  YW  current row
- valid  out  1  x_addr/y_addr valid for the datapath this cycle
- row_done  out  1  one-cycle pulse when the row's temp cycle completes
- frame_done  out  1  one-cycle pulse after the last row completes
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous and active-low on rst; clock is clk.
- Reset values: state=IDLE; x_addr=0, y_addr=0; x_zero, valid, row_done, frame_done, busy all 0. All outputs are registered.
- IDLE:
  - start=1 → SCAN next cycle with x=0, y=0.
  - temp_done and temp_busy are ignored. The temp sequencer free-runs from its reset value 6 and emits one temp_done ~4 cycles after reset; this pulse must not advance anything.
- SCAN:
  - valid=1 every cycle; x_addr increments by 1 per cycle.
  - In the cycle x_addr==COLS-1: the next state is WAIT_TEMP, x_addr wraps to 0, and x_zero is registered high.
  - x_zero is therefore high for exactly one cycle, the first cycle of WAIT_TEMP.
  - start is ignored.
- WAIT_TEMP:
  - valid=0; addresses hold (x=0, y=current row).
  - On temp_done=1, row_done pulses in the next cycle, and:
    - if y_addr==ROWS-1 → DONE, y_addr holds;
    - otherwise y_addr+1 and → SCAN.
  - Expected stall is 10 cycles from the x_zero cycle to temp_done. The block must not depend on that value.
- DONE: frame_done=1 for one cycle; y_addr clears to 0; → IDLE. busy drops in the cycle after DONE.
- Simultaneous events:
  - start outside IDLE is ignored (it is not queued).
  - temp_done in SCAN or DONE is ignored.
  - temp_done in the same cycle x_zero is high is accepted (sequencer latency 0 is legal).
- Reset mid-operation: immediate return to reset values. No x_zero is generated on reset release.
- Arithmetic: x_addr and y_addr are unsigned with compare-and-clear wrap. No natural-overflow wrap is used.

Optional Feature:
- Macro: SCAN_CTRL_L9_CHK_EN.
- When defined, add an output err_sticky (1 bit, reset 0). It sets and holds until rst when either:
  - x_zero would be issued while temp_busy=1 (sequencer not idle); or
  - temp_done=1 in SCAN (a spurious completion).
- err_sticky has no effect on the FSM.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, start held 0 for 20 cycles with the sequencer model emitting temp_done at cycle 4 → state stays IDLE; busy, valid, x_zero, row_done, frame_done all 0.
- COLS=14, ROWS=2, start pulse at cycle 0 →
  - valid high cycles 1–14 with x_addr 0..13, y_addr=0;
  - x_zero high at cycle 15 only;
  - sequencer returns temp_done 10 cycles later → row_done one cycle later; row 1 repeats with y_addr=1;
  - frame_done pulses once; busy low afterwards.
- temp_done tied high in WAIT_TEMP (zero-latency sequencer), ROWS=3 → each row's stall is 1 cycle; exactly 3 row_done pulses and 1 frame_done.
- start re-pulsed during SCAN, and temp_done injected during SCAN → no restart and no address disturbance; with SCAN_CTRL_L9_CHK_EN, err_sticky=1 and stays 1.
- rst asserted in WAIT_TEMP of row 5 → all outputs 0 asynchronously. After release plus start, the scan restarts from x=0, y=0 with no stray x_zero.
- COLS=2, ROWS=1 boundary → valid for 2 cycles, x_zero once, frame_done once after temp_done.
